// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared definitions for the pipeline trace recorder: FSM state encoding,
// entry width formula and the field offsets of a packed trace entry.
// Entry layout (MSB..LSB): {stamp, stage_vld, stage_pc}.
// No ports (package).
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic int entry_w(input int stages, input int addr_w, input int stamp_w);
        return stamp_w + stages + stages * addr_w;
    endfunction

    function automatic int pc_lsb();
        return 0;
    endfunction

    function automatic int vld_lsb(input int stages, input int addr_w);
        return stages * addr_w;
    endfunction

    function automatic int stamp_lsb(input int stages, input int addr_w);
        return stages * addr_w + stages;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// Simple dual-port storage for trace entries: synchronous write, registered
// read. Array contents are not reset; only the read register is.
// Ports:
//   clk, rst          clock, synchronous active-high reset (read register only)
//   wr_en/wr_addr/wr_data   write port
//   rd_en/rd_addr     read request, data appears on rd_data the next cycle
//   rd_data           registered read data
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// pipe_trace_buffer
// On-chip trace recorder for the 5-stage pipeline. While armed, every cycle
// stores {stamp, stage_vld, stage_pc} into a circular buffer. A trigger
// freezes the buffer POST_CNT entries later; the frozen window is then read
// out oldest-first, one entry per rd_en.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   arm             start / restart recording (beats trig)
//   trig            trigger event (ARMED only)
//   stage_pc        per-stage PCs, stage k at [k*ADDR_W +: ADDR_W], k=0 is IF
//   stage_vld       per-stage valid bits (0 = bubble)
//   rd_en           request next entry (DONE only)
//   armed/triggered/done   state decodes (ARMED / POST / DONE)
//   fill            entries held
//   rd_vld, rd_data, rd_trig, rd_last   read response, one cycle after rd_en
// -----------------------------------------------------------------------------
module pipe_trace_buffer
    import trace_pkg::*;
#(
    parameter int STAGES   = 5,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 16,
    parameter int POST_CNT = 8,
    parameter int STAMP_W  = 16,
    localparam int ENTRY_W = entry_w(STAGES, ADDR_W, STAMP_W),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     trig,
    input  logic [STAGES*ADDR_W-1:0] stage_pc,
    input  logic [STAGES-1:0]        stage_vld,
    input  logic                     rd_en,
    output logic                     armed,
    output logic                     triggered,
    output logic                     done,
    output logic [CNT_W-1:0]         fill,
    output logic                     rd_vld,
    output logic [ENTRY_W-1:0]       rd_data,
    output logic                     rd_trig,
    output logic                     rd_last
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [1:0]         state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   trig_ptr;
    logic [CNT_W-1:0]   post_left;
    logic [CNT_W-1:0]   rd_cnt;
    logic [STAMP_W-1:0] stamp;

    logic               wr_en;
    logic               rd_fire;
    logic [PTR_W-1:0]   oldest;
    logic [PTR_W-1:0]   rd_addr;
    logic [ENTRY_W-1:0] wr_data;

    assign armed     = (state == ST_ARMED);
    assign triggered = (state == ST_POST);
    assign done      = (state == ST_DONE);

    // A restart cycle does not record; the first entry lands the cycle after arm.
    assign wr_en   = (state == ST_ARMED || state == ST_POST) && !arm;
    assign rd_fire = (state == ST_DONE) && rd_en && !arm && (rd_cnt != fill);

    // Window is frozen in DONE, so the read address is derived from the
    // stopped write pointer rather than a separately loaded read pointer.
    // fill == DEPTH truncates to 0, making the oldest entry wr_ptr itself.
    assign oldest  = wr_ptr - fill[PTR_W-1:0];
    assign rd_addr = oldest + rd_cnt[PTR_W-1:0];

    always_comb begin
        wr_data = '0;
        wr_data[pc_lsb() +: STAGES*ADDR_W]           = stage_pc;
        wr_data[vld_lsb(STAGES, ADDR_W) +: STAGES]   = stage_vld;
        wr_data[stamp_lsb(STAGES, ADDR_W) +: STAMP_W] = stamp;
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            trig_ptr  <= '0;
            fill      <= '0;
            post_left <= '0;
            rd_cnt    <= '0;
            stamp     <= '0;
            rd_vld    <= 1'b0;
            rd_trig   <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            stamp   <= stamp + 1'b1;
            rd_vld  <= rd_fire;
            rd_trig <= rd_fire && (rd_addr == trig_ptr);
            rd_last <= rd_fire && (rd_cnt == fill - 1'b1);

            if (arm) begin
                state     <= ST_ARMED;
                wr_ptr    <= '0;
                fill      <= '0;
                post_left <= '0;
                rd_cnt    <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        wr_ptr <= '0;
                        fill   <= '0;
                        rd_cnt <= '0;
                    end
                    ST_ARMED: begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (fill != CNT_W'(DEPTH)) begin
                            fill <= fill + 1'b1;
                        end
                        if (trig) begin
                            trig_ptr <= wr_ptr;
                            if (POST_CNT == 0) begin
                                state <= ST_DONE;
                            end else begin
                                state     <= ST_POST;
                                post_left <= CNT_W'(POST_CNT);
                            end
                        end
                    end
                    ST_POST: begin
                        wr_ptr    <= wr_ptr + 1'b1;
                        post_left <= post_left - 1'b1;
                        if (fill != CNT_W'(DEPTH)) begin
                            fill <= fill + 1'b1;
                        end
                        if (post_left == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                    default: begin
                        if (rd_fire) begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_trace_buffer
// Self-checking bench for pipe_trace_buffer (DEPTH=8, POST_CNT=4, STAGES=5).
// Driven entries are recorded with their expected stamp; each rd_en pushes the
// expected window entry onto a queue, popped when rd_vld is seen.
// -----------------------------------------------------------------------------
module tb_pipe_trace_buffer;

    localparam int STAGES   = 5;
    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 8;
    localparam int POST_CNT = 4;
    localparam int STAMP_W  = 16;
    localparam int EW       = trace_pkg::entry_w(STAGES, ADDR_W, STAMP_W);
    localparam int CW       = $clog2(DEPTH) + 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     arm;
    logic                     trig;
    logic [STAGES*ADDR_W-1:0] stage_pc;
    logic [STAGES-1:0]        stage_vld;
    logic                     rd_en;
    logic                     armed;
    logic                     triggered;
    logic                     done;
    logic [CW-1:0]            fill;
    logic                     rd_vld;
    logic [EW-1:0]            rd_data;
    logic                     rd_trig;
    logic                     rd_last;

    typedef struct packed {
        logic [EW-1:0] data;
        logic          trg;
        logic          last;
    } exp_t;

    exp_t          exp_q[$];
    logic [EW-1:0] hist[$];
    int            trig_idx;
    int            pulses;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [STAMP_W-1:0] tb_stamp;

    always #5 clk = ~clk;

    pipe_trace_buffer #(
        .STAGES   (STAGES),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .POST_CNT (POST_CNT),
        .STAMP_W  (STAMP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .trig      (trig),
        .stage_pc  (stage_pc),
        .stage_vld (stage_vld),
        .rd_en     (rd_en),
        .armed     (armed),
        .triggered (triggered),
        .done      (done),
        .fill      (fill),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .rd_trig   (rd_trig),
        .rd_last   (rd_last)
    );

    // Reference stamp: value the DUT samples at the next posedge.
    always @(posedge clk) begin
        if (rst) tb_stamp <= '0;
        else     tb_stamp <= tb_stamp + 1'b1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_vld === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("rd_unexpected", rd_vld, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_trig", rd_trig, e.trg);
                check("rd_last", rd_last, e.last);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [EW-1:0] make_entry(input int i, input logic [STAGES-1:0] v,
                                                 input logic [STAMP_W-1:0] s);
        logic [STAGES*ADDR_W-1:0] pcs;
        for (int k = 0; k < STAGES; k++) pcs[k*ADDR_W +: ADDR_W] = 32'(4*i - 4*k);
        return {s, v, pcs};
    endfunction

    task automatic drive_entry(input int i, input logic [STAGES-1:0] v, input logic trg);
        logic [EW-1:0] e;
        e = make_entry(i, v, tb_stamp);
        stage_pc  = e[STAGES*ADDR_W-1:0];
        stage_vld = v;
        trig      = trg;
        hist.push_back(e);
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_armed"}, armed, 0);
        check({tag, "_triggered"}, triggered, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fill"}, fill, 0);
        check({tag, "_rd_vld"}, rd_vld, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_trig"}, rd_trig, 0);
        check({tag, "_rd_last"}, rd_last, 0);
    endtask

    // Arm, record until DONE. extra_trig lands during POST; bubble_at gets 5'b10110.
    task automatic record(input int t_at, input int extra_trig, input int bubble_at);
        int n;
        int f;
        n = t_at + 1 + POST_CNT;
        f = (n < DEPTH) ? n : DEPTH;
        hist.delete();
        trig_idx = t_at;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_armed", armed, 1);
        check("arm_fill", fill, 0);
        for (int i = 0; i < n; i++) begin
            drive_entry(i, (i == bubble_at) ? 5'b10110 : 5'b11111,
                        (i == t_at) || (i == extra_trig));
            if (i == t_at) check("trig_triggered", triggered, 1);
        end
        trig = 1'b0;
        check("rec_done", done, 1);
        check("rec_triggered", triggered, 0);
        check("rec_fill", fill, f);
    endtask

    task automatic readout(input int nreq, input bit arm_after);
        int n;
        int f;
        exp_t e;
        n = hist.size();
        f = (n < DEPTH) ? n : DEPTH;
        pulses = 0;
        for (int r = 0; r < nreq; r++) begin
            rd_en = 1'b1;
            if (r < f) begin
                e.data = hist[n-f+r];
                e.trg  = (n - f + r == trig_idx);
                e.last = (r == f - 1);
                exp_q.push_back(e);
            end
            tick();
        end
        rd_en = 1'b0;
        if (arm_after) begin
            arm = 1'b1;
            tick();
            arm = 1'b0;
            check("rearm_armed", armed, 1);
            check("rearm_done", done, 0);
            check("rearm_fill", fill, 0);
            tick();
            check("rearm_rd_vld", rd_vld, 0);
            check("rearm_queue", exp_q.size(), 0);
        end else begin
            tick();
            tick();
            check("rd_pulses", pulses, (nreq < f) ? nreq : f);
            check("rd_queue", exp_q.size(), 0);
        end
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
        stage_pc = '0; stage_vld = '0;
        trig_idx = -1; pulses = 0;

        // Reset held with control inputs toggling
        for (int i = 0; i < 2; i++) begin
            arm = (i == 0); trig = (i == 1); rd_en = (i == 0);
            tick();
        end
        check_idle_outputs("reset");
        rst = 1'b0; arm = 1'b0; trig = 1'b0; rd_en = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // trig / rd_en in IDLE are ignored
        trig = 1'b1; rd_en = 1'b1;
        tick();
        trig = 1'b0; rd_en = 1'b0;
        tick();
        check_idle_outputs("idle_ignore");

        // Full window, trigger on entry 11, extra trig during POST, bubble on 9,
        // then 10 reads against an 8-entry window
        record(11, 13, 9);
        readout(10, 1'b0);

        // Early trigger on entry 1
        record(1, -1, -1);
        readout(6, 1'b0);

        // arm during readout
        record(3, -1, -1);
        readout(3, 1'b1);

        // arm + trig together from ARMED: restart, no trigger
        arm = 1'b1; trig = 1'b1;
        tick();
        arm = 1'b0; trig = 1'b0;
        check("armtrig_armed", armed, 1);
        check("armtrig_triggered", triggered, 0);
        tick();
        check("armtrig_armed2", armed, 1);
        check("armtrig_triggered2", triggered, 0);

        // Reset during POST
        hist.delete();
        drive_entry(0, 5'b11111, 1'b1);
        trig = 1'b0;
        check("abort_triggered", triggered, 1);
        drive_entry(1, 5'b11111, 1'b0);
        rst = 1'b1;
        tick();
        check_idle_outputs("abort");
        rst = 1'b0;
        record(2, -1, -1);
        readout(8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pipe_trace_buffer.md
# pipe_trace_buffer

Synthesizable on-chip trace recorder for the 5-stage pipelined CPU. Each cycle it captures every stage's PC and valid bit plus a cycle stamp into a circular buffer. Recording stops a programmable number of entries after a trigger, and the frozen window is then streamed out oldest-first. It sits beside `PipeLine_CPU`, fed from the per-stage PC registers (IF/ID/Ex/Mem/Wr), and replaces post-mortem file dumps for long runs.

## Interface
- `STAGES`, 5, number of pipeline stages traced
- `ADDR_W`, 32, PC width per stage
- `DEPTH`, 16, buffer entries; power of two, ≥ 2
- `POST_CNT`, 8, entries recorded after the trigger entry; range 0..DEPTH-1
- `STAMP_W`, 16, cycle-stamp width
- Derived: `ENTRY_W` = STAMP_W + STAGES + STAGES·ADDR_W; `CNT_W` = log2(DEPTH)+1

Ports:
- `clk` in 1: single clock, all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `arm` in 1: start or restart recording
- `trig` in 1: trigger event
- `stage_pc` in STAGES·ADDR_W: stage k's PC at bits [k·ADDR_W +: ADDR_W]; k=0 is IF
- `stage_vld` in STAGES: per-stage valid; 0 marks a bubble
- `rd_en` in 1: request the next entry
- `armed` out 1: in ARMED state
- `triggered` out 1: in POST state
- `done` out 1: in DONE state
- `fill` out CNT_W: entries held
- `rd_vld` out 1: `rd_data` valid this cycle
- `rd_data` out ENTRY_W: entry as {stamp, stage_vld, stage_pc}
- `rd_trig` out 1: the entry being read is the trigger entry
- `rd_last` out 1: the entry being read is the final one

## Operation
- FSM states: IDLE → ARMED → POST → DONE.
- IDLE:
  - `arm` → ARMED.
  - Pointers and `fill` clear.
  - `trig` and `rd_en` are ignored.
- ARMED:
  - One entry is written every cycle at `wr_ptr`; `wr_ptr` wraps modulo DEPTH.
  - `fill` saturates at DEPTH.
  - `trig` = 1: the same-cycle entry is written and flagged as the trigger (`trig_ptr` stored).
    - POST_CNT = 0 → DONE.
    - Otherwise → POST with `post_left` = POST_CNT.
- POST:
  - Writes continue; `post_left` decrements per write.
  - The write with `post_left` = 1 → DONE.
  - `trig` is ignored.
- DONE:
  - Writes stop.
  - `rd_ptr` starts at the oldest entry, (`wr_ptr` − `fill`) mod DEPTH, and `rd_left` = `fill`.
  - Each `rd_en` with `rd_left` > 0 reads one entry and advances the pointer.
  - `rd_en` with `rd_left` = 0 is ignored.
- `arm` in ARMED, POST or DONE restarts: `fill`, pointers and readout clear, → ARMED. `arm` has priority over `trig` in the same cycle.
- Cycle stamp: free-running STAMP_W counter, cleared by `rst`, wraps to 0.
- Memory contents are not reset; only `fill` defines validity.

## Timing
- All outputs reset to 0 on the cycle after `rst` is sampled high.
- A `rst` arriving mid-record or mid-read aborts immediately.
- Write latency: inputs sampled at posedge N appear in the array at N+1. The entry stamp equals the counter value at sampling.
- `armed` / `triggered` / `done` are registered state decodes and change the cycle after the causing input.
- Read latency: `rd_en` sampled at posedge N → `rd_vld`, `rd_data`, `rd_trig`, `rd_last` valid after posedge N+1 for exactly one cycle.
- Back-to-back `rd_en` gives one entry per cycle.
- Early trigger (`fill` < DEPTH at trigger): the window is simply shorter and the oldest entry is the first one recorded.

## Structure
- A shared package `trace_pkg` holds:
  - the state encoding (IDLE=0, ARMED=1, POST=2, DONE=3);
  - the `ENTRY_W` formula;
  - the field offsets of `rd_data`.
- Sub-module `trace_ram`: simple dual-port array with DEPTH×ENTRY_W, synchronous write, registered read.
- The top level holds the FSM, pointers, stamp counter and readout.

## Test plan
All scenarios use DEPTH=8, POST_CNT=4, STAGES=5. The IF PC for entry i is 4·i, and stage k = IF − 4k.

1. Reset: hold `rst` for 2 cycles with `arm`/`trig`/`rd_en` toggling → all outputs 0, `fill`=0, state IDLE.
2. Full-window capture: `arm`, then `trig` on entry 11 →
   - `done` after entry 15; `fill`=8;
   - 8 reads return IF PCs 0x20..0x3C;
   - `rd_trig` on the 4th read (0x2C);
   - `rd_last` on 0x3C;
   - stamps are consecutive.
3. Early trigger on entry 1 → `fill`=6; reads return IF 0x00..0x14; `rd_trig` on the 2nd read.
4. Assert `rst` during POST → next cycle all outputs 0. Re-arming then records from a fresh stamp of 0.
5. Ignored and priority events:
   - `trig` in IDLE and during POST: no effect.
   - `arm` in DONE mid-readout: `rd_vld` drops, `fill`=0, state ARMED.
   - `arm`+`trig` together: ARMED, no trigger.
6. Bubbles and overrun:
   - `stage_vld`=5'b10110 on one entry → read back with identical bits.
   - 10 `rd_en` after an 8-entry window → exactly 8 `rd_vld` pulses.
